// File: rtl/lsa_mem_arbiter.sv
// Purpose : shares one async-read memory between the lsa core (fixed priority) and a host/loader port.
// Latency : host access performed in the grant cycle, host_ack one cycle later; core path is combinational.
// Backpres: the core is never stalled; host_req waits (held high) while the core is active, up to one access per 2 cycles.
//
// Ports:
//   clock_in, reset_in             - clock (rising edge) and asynchronous active-low reset
//   core_oe/we/add/wdata, core_rdata - core memory port (rdata is mem_rdata passed through)
//   core_reset_n, halted           - core reset output driven from the run register and its inverse
//   host_req/we/add/wdata          - host request, held until host_ack
//   host_ack, host_rdata           - completion pulse and registered read data
//   host_halt                      - level request to hold the core in reset
//   host_starved                   - host request pending for STARVE_LIMIT cycles
//   mem_oe/we/add/wdata, mem_rdata - shared memory port
//
// Optional feature macro: LSA_ARB_STARVE_EN builds the starvation counter; otherwise host_starved is 0.
module lsa_mem_arbiter #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        core_oe,
    input  logic        core_we,
    input  logic [15:0] core_add,
    input  logic [15:0] core_wdata,
    output logic [15:0] core_rdata,
    output logic        core_reset_n,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_add,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    input  logic        host_halt,
    output logic        halted,
    output logic        host_starved,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [15:0] mem_add,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } host_state_t;

    host_state_t state, state_nxt;
    logic        core_run;
    logic        core_active;
    logic        grant;

    // Run register: halt requests reach the core reset one edge later.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) core_run <= 1'b0;
        else           core_run <= ~host_halt;
    end

    assign core_reset_n = core_run;
    assign halted       = ~core_run;

    // A core held in reset still drives its strobes, so they are masked here.
    assign core_active = core_run & (core_oe | core_we);

    assign grant = (state == H_IDLE) & host_req & ~core_active;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) state <= H_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        host_ack  = 1'b0;
        case (state)
            H_IDLE: if (grant) state_nxt = H_ACK;
            H_ACK: begin
                host_ack  = 1'b1;
                state_nxt = H_IDLE;
            end
            default: state_nxt = H_IDLE;
        endcase
    end

    // Capture read data at the closing edge of a read grant; hold otherwise.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in)              host_rdata <= 16'h0000;
        else if (grant && !host_we) host_rdata <= mem_rdata;
    end

    // Memory mux: core first, then a granted host, else idle bus.
    always_comb begin
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        mem_add   = 16'h0000;
        mem_wdata = 16'h0000;
        if (core_active) begin
            mem_oe    = core_oe;
            mem_we    = core_we;
            mem_add   = core_add;
            mem_wdata = core_wdata;
        end else if (grant) begin
            mem_oe    = ~host_we;
            mem_we    = host_we;
            mem_add   = host_add;
            mem_wdata = host_wdata;
        end
    end

    assign core_rdata = mem_rdata;

`ifdef LSA_ARB_STARVE_EN
    logic [7:0] starve_cnt;

    // Counts H_IDLE cycles with a pending but ungranted request; saturates at the limit.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            starve_cnt <= 8'd0;
        end else if (grant) begin
            starve_cnt <= 8'd0;
        end else if ((state == H_IDLE) && host_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign host_starved = (starve_cnt == LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^LIMIT;
    assign host_starved = 1'b0;
`endif

endmodule

// File: doc/lsa_mem_arbiter.md
# lsa_mem_arbiter

Shares the single asynchronous-read memory between the lsa core and a host/loader port (UART or JTAG bridge) on the plutoII board. The core always has priority, because it cannot stall. The host gets idle memory slots through a req/ack handshake. The host can also halt the core by holding the core's reset, which gives it exclusive memory access for program loading.

## Interface
Parameters:
- STARVE_LIMIT, 64: number of ungranted host-request cycles before host_starved asserts (1..255).

Ports:
- clock_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- core_oe  input  1  core read strobe.
- core_we  input  1  core write strobe.
- core_add  input  16  core address.
- core_wdata  input  16  core write data.
- core_rdata  output  16  read data to core, equal to mem_rdata (combinational).
- core_reset_n  output  1  active-low reset to core; low while halted.
- host_req  input  1  host access request; held until host_ack.
- host_we  input  1  1 = write, 0 = read; stable while host_req is high.
- host_add  input  16  host address; stable while host_req is high.
- host_wdata  input  16  host write data; stable while host_req is high.
- host_ack  output  1  one-cycle completion pulse.
- host_rdata  output  16  registered read data; valid from host_ack onward.
- host_halt  input  1  level request to hold the core in reset.
- halted  output  1  high while core_reset_n is low.
- host_starved  output  1  host request pending for at least STARVE_LIMIT cycles.
- mem_oe, mem_we  output  1  memory read and write strobes.
- mem_add  output  16  memory address.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data (asynchronous, same-cycle).

## Operation
- Run register core_run:
  - Resets to 0.
  - Every edge: core_run <= ~host_halt.
  - core_reset_n = core_run; halted = ~core_run.
- Definition: core_active = core_run & (core_oe | core_we).
  - Core strobes are ignored while halted. This is required because the core drives mem_oe=1 while it is held in reset.
- Downstream mux, combinational:
  - When core_active: mem_* = core_*.
  - When the host is granted: mem_add = host_add, mem_wdata = host_wdata, mem_we = host_we, mem_oe = ~host_we.
  - Otherwise: all mem_* = 0.
- Host FSM has two states:
  - H_IDLE: grant when host_req & ~core_active, then go to H_ACK. A grant performs the memory access in that same cycle; for a read, host_rdata <= mem_rdata at the closing edge.
  - H_ACK: host_ack = 1. host_req is ignored during this cycle. Next state is H_IDLE.
- Maximum host throughput is one access per 2 cycles.
- The core is never blocked. A host request waits as long as core_active stays high.
- If the core drives oe and we together, both are passed through unchanged.
- Starvation counter (8-bit):
  - Increments each H_IDLE cycle in which host_req is high but no grant occurs.
  - Clears on grant; saturates at STARVE_LIMIT.
  - host_starved = (count == STARVE_LIMIT).
- Reset mid-operation: any pending host transaction is dropped. The host must reissue it after reset.

## Timing
- Reset values:
  - core_run = 0, so core_reset_n = 0 and halted = 1.
  - FSM = H_IDLE; host_ack = 0; host_rdata = 0x0000; count = 0; host_starved = 0.
  - mem_* outputs are 0, because core_run = 0 and there is no grant.
- First edge after reset_in rises with host_halt = 0: core_reset_n goes to 1.
- host_halt changes take effect on core_reset_n one edge later, in both directions.
- A core write on the same edge that halt asserts still commits, since core_run is still 1 in that cycle.
- Host latency:
  - Grant in cycle N (request in N, core idle): host_ack in N+1.
  - Minimum request-to-ack latency is 1 cycle.
- host_rdata is updated only at a read-grant edge and holds its value otherwise.
- Halt during H_ACK: the ack still completes.

## Configuration
- LSA_ARB_STARVE_EN:
  - Defined: the starvation counter and host_starved are built as described above.
  - Undefined: no counter logic is built, host_starved is tied to 0, and STARVE_LIMIT is unused.

## Test plan
- Host read, core idle: memory preloaded with mem[0x0010] = 0xBEEF, host_halt = 1, read request to 0x0010 -> mem_oe = 1 and mem_add = 0x0010 in cycle N; host_ack in N+1; host_rdata = 0xBEEF.
- Contention: core_oe held high for 5 cycles while the host requests a write of 0x1234 to 0x0020 -> no host grant for those 5 cycles; grant in cycle 6; host_ack in cycle 7; mem[0x0020] = 0x1234.
- Halt masking: host_halt = 1 while the core drives core_oe = 1 and core_add = 0x0000 -> halted = 1; host accesses at 0x0005 are granted immediately, with mem_add = 0x0005.
- Halt/release: host_halt 0->1->0 -> core_reset_n falls one edge after host_halt rises and rises one edge after it falls.
- Starvation: with LSA_ARB_STARVE_EN defined and STARVE_LIMIT = 4, core_active held high for 10 cycles with the host requesting -> host_starved = 1 after 4 pending cycles; it clears on the edge after the grant.
- Async reset mid-transaction: reset_in pulsed low in H_ACK -> host_ack = 0, host_rdata = 0x0000 and core_reset_n = 0 immediately.
